// File: rtl/envelope_vca.sv
// Voice VCA: slew-limited envelope gain applied to a signed sample stream
// through a 3-stage valid/ready pipeline (register, multiply, round).
module envelope_vca #(
    parameter int                        DATA_WIDTH     = 24,
    parameter int                        ENVELOPE_WIDTH = 32,
    parameter logic [ENVELOPE_WIDTH-1:0] SLEW_STEP      = 32'h0020_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ENVELOPE_WIDTH-1:0] envelope_in,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ENVELOPE_WIDTH-1:0] env_level,
    output logic                      active
);

    localparam int PW = DATA_WIDTH + ENVELOPE_WIDTH + 1;
    localparam logic [ENVELOPE_WIDTH-1:0] UNITY = {1'b0, {(ENVELOPE_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] ROUND = PW'(64'd1 << (ENVELOPE_WIDTH - 2));

    logic                       adv;
    logic                       accept;
    logic [ENVELOPE_WIDTH-1:0]  tgt;
    logic [ENVELOPE_WIDTH-1:0]  env_cur;
    logic [ENVELOPE_WIDTH-1:0]  env_next;
    logic [ENVELOPE_WIDTH:0]    up_diff;
    logic [ENVELOPE_WIDTH:0]    down_diff;

    logic signed [DATA_WIDTH-1:0] s1_d;
    logic [ENVELOPE_WIDTH-1:0]    s1_g;
    logic                         v1;
    logic signed [PW-1:0]         prod;
    logic                         v2;
    logic signed [PW-1:0]         rounded;
    logic signed [DATA_WIDTH-1:0] scaled;

    assign adv       = ~m_valid | m_ready;
    assign s_ready   = adv;
    assign accept    = s_valid & adv;
    assign env_level = env_cur;
    assign active    = (env_cur != '0) | v1 | v2 | m_valid;

    // Slew limiter; differences are taken one bit wider so they never wrap.
    always_comb begin
        tgt       = envelope_in[ENVELOPE_WIDTH-1] ? UNITY : envelope_in;
        up_diff   = {1'b0, tgt} - {1'b0, env_cur};
        down_diff = {1'b0, env_cur} - {1'b0, tgt};
        env_next  = tgt;
        if (SLEW_STEP != '0) begin
            if (tgt > env_cur && up_diff > {1'b0, SLEW_STEP})
                env_next = env_cur + SLEW_STEP;
            else if (tgt < env_cur && down_diff > {1'b0, SLEW_STEP})
                env_next = env_cur - SLEW_STEP;
        end
    end

    // Round half up, then keep the low DATA_WIDTH bits of the arithmetic shift;
    // gain never exceeds unity, so the result always fits.
    assign rounded = prod + ROUND;
    assign scaled  = DATA_WIDTH'(rounded >>> (ENVELOPE_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            env_cur <= '0;
        end else if (adv) begin
            v1      <= accept;
            v2      <= v1;
            m_valid <= v2;
            if (v2)
                m_data <= scaled;
            if (accept)
                env_cur <= env_next;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (accept) begin
                s1_d <= s_data;
                s1_g <= env_next;
            end
            if (v1)
                prod <= $signed({{(ENVELOPE_WIDTH+1){s1_d[DATA_WIDTH-1]}}, s1_d})
                      * $signed({{(DATA_WIDTH+1){1'b0}}, s1_g});
        end
    end

endmodule

// File: tb/tb_envelope_vca.sv
// Randomized and directed bench for envelope_vca: an unsmoothed and a default-slew
// instance share stimulus and are scored against a queue-based arithmetic model.
module tb_envelope_vca;

    localparam int DW = 24;
    localparam int EW = 32;
    localparam longint SLEW_B = 64'h0020_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [EW-1:0] envelope_in;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          m_ready;

    logic          s_ready_a, m_valid_a, active_a;
    logic [DW-1:0] m_data_a;
    logic [EW-1:0] env_level_a;
    logic          s_ready_b, m_valid_b, active_b;
    logic [DW-1:0] m_data_b;
    logic [EW-1:0] env_level_b;

    always #5 clk = ~clk;

    envelope_vca #(.SLEW_STEP(32'h0)) dut_a (
        .clk(clk), .rst(rst), .envelope_in(envelope_in),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .env_level(env_level_a), .active(active_a)
    );

    envelope_vca dut_b (
        .clk(clk), .rst(rst), .envelope_in(envelope_in),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .env_level(env_level_b), .active(active_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: current gain of each instance, expected outputs in order.
    longint env_a = 0;
    longint env_b = 0;
    longint qa[$];
    longint qb[$];

    // Values sampled at the falling edge by tick().
    logic   smp_acc, smp_hs, smp_s_ready, smp_m_valid;
    longint smp_data_a, smp_data_b;
    int     smp_cyc;

    function automatic longint clamp_tgt(logic [EW-1:0] e);
        return e[EW-1] ? 64'h7FFF_FFFF : longint'({32'h0, e});
    endfunction

    function automatic longint slew(longint cur, longint tgt, longint step);
        if (step == 0) return tgt;
        if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
        return (cur - tgt <= step) ? tgt : cur - step;
    endfunction

    // floor((x*g + 2^30) / 2^31) using explicit floor division.
    function automatic longint scale(longint x, longint g);
        longint num, d, q;
        num = x * g + 64'sd1073741824;
        d   = 64'sd2147483648;
        q   = num / d;
        if (num < 0 && (num % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic tick();
        longint tgt, x, exp_a, exp_b;
        logic   act_a_exp, act_b_exp;
        @(negedge clk);
        smp_cyc     = cyc;
        smp_s_ready = s_ready_a;
        smp_m_valid = m_valid_a;
        smp_acc     = s_valid && s_ready_a;
        smp_hs      = m_valid_a && m_ready;
        smp_data_a  = longint'($signed(m_data_a));
        smp_data_b  = longint'($signed(m_data_b));

        checks++;
        if (s_ready_a !== (!m_valid_a || m_ready)) begin
            errors++;
            $display("FAIL s_ready: got %b expected %b", s_ready_a, !m_valid_a || m_ready);
        end
        checks++;
        if (s_ready_b !== s_ready_a || m_valid_b !== m_valid_a) begin
            errors++;
            $display("FAIL handshake_b: got s_ready=%b m_valid=%b expected %b %b",
                     s_ready_b, m_valid_b, s_ready_a, m_valid_a);
        end
        act_a_exp = (env_a != 0) || (qa.size() != 0);
        act_b_exp = (env_b != 0) || (qb.size() != 0);
        checks++;
        if (active_a !== act_a_exp || active_b !== act_b_exp) begin
            errors++;
            $display("FAIL active: got a=%b b=%b expected a=%b b=%b",
                     active_a, active_b, act_a_exp, act_b_exp);
        end

        if (smp_hs) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got data %0d expected none", smp_data_a);
            end else begin
                exp_a = qa.pop_front();
                exp_b = qb.pop_front();
                if (smp_data_a !== exp_a) begin
                    errors++;
                    $display("FAIL out_a: got %0d expected %0d", smp_data_a, exp_a);
                end
                checks++;
                if (smp_data_b !== exp_b) begin
                    errors++;
                    $display("FAIL out_b: got %0d expected %0d", smp_data_b, exp_b);
                end
            end
        end

        if (smp_acc) begin
            tgt   = clamp_tgt(envelope_in);
            env_a = slew(env_a, tgt, 0);
            env_b = slew(env_b, tgt, SLEW_B);
            x     = longint'($signed(s_data));
            qa.push_back(scale(x, env_a));
            qb.push_back(scale(x, env_b));
        end

        @(posedge clk);
        #1;
        cyc++;
        if (smp_acc) begin
            checks++;
            if (longint'({32'h0, env_level_a}) !== env_a || longint'({32'h0, env_level_b}) !== env_b) begin
                errors++;
                $display("FAIL env_level: got a=%h b=%h expected a=%h b=%h",
                         env_level_a, env_level_b, env_a, env_b);
            end
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0) break;
            tick();
        end
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", qa.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic send(logic [DW-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        smp_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (smp_acc) break;
        end
        s_valid = 1'b0;
        checks++;
        if (!smp_acc) begin
            errors++;
            $display("FAIL send_timeout: got no accept expected accept of %0d", $signed(v));
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        s_valid     = 1'b0;
        m_ready     = 1'b1;
        envelope_in = '0;
        s_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_valid: got %b %b expected 0 0", m_valid_a, m_valid_b);
        end
        checks++;
        if (m_data_a !== '0 || m_data_b !== '0) begin
            errors++;
            $display("FAIL reset_m_data: got %h %h expected 0 0", m_data_a, m_data_b);
        end
        checks++;
        if (env_level_a !== '0 || env_level_b !== '0) begin
            errors++;
            $display("FAIL reset_env_level: got %h %h expected 0 0", env_level_a, env_level_b);
        end
        checks++;
        if (active_a !== 1'b0 || active_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_active: got %b %b expected 0 0", active_a, active_b);
        end
        checks++;
        if (s_ready_a !== 1'b1 || s_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %b %b expected 1 1", s_ready_a, s_ready_b);
        end
    endtask

    task automatic test_unity();
        logic [DW-1:0] vals [4];
        int first_acc = -1, first_val = -1, last_hs = -1, nout = 0;
        vals = '{24'h7FFFFF, 24'h800000, 24'h000001, 24'hFFFFFF};
        envelope_in = 32'h7FFF_FFFF;
        m_ready     = 1'b1;
        for (int t = 0; t < 12; t++) begin
            s_valid = (t < 4);
            if (t < 4) s_data = vals[t];
            tick();
            if (smp_acc && first_acc < 0) first_acc = smp_cyc;
            if (smp_m_valid && first_val < 0) first_val = smp_cyc;
            if (smp_hs) begin
                last_hs = smp_cyc;
                if (nout < 4) begin
                    checks++;
                    if (smp_data_a !== longint'($signed(vals[nout]))) begin
                        errors++;
                        $display("FAIL unity_identity: got %0d expected %0d",
                                 smp_data_a, $signed(vals[nout]));
                    end
                end
                nout++;
            end
        end
        checks++;
        if (first_val - first_acc != 3) begin
            errors++;
            $display("FAIL latency: got %0d expected 3", first_val - first_acc);
        end
        checks++;
        if (nout != 4 || last_hs - first_val != 3) begin
            errors++;
            $display("FAIL throughput: got %0d outputs over %0d cycles expected 4 over 3",
                     nout, last_hs - first_val);
        end
        drain();
    endtask

    task automatic test_half();
        envelope_in = 32'h4000_0000;
        m_ready     = 1'b1;
        send(24'd1000);
        send(-24'sd1000);
        send(24'd3);
        drain();
    endtask

    task automatic test_clamp();
        envelope_in = 32'hFFFF_FFFF;
        send(24'd12345);
        checks++;
        if (env_level_a !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL clamp_env: got %h expected 7fffffff", env_level_a);
        end
        drain();
    endtask

    task automatic test_ramp();
        int     n = 0;
        longint last_b = -1;
        envelope_in = '0;
        m_ready     = 1'b1;
        s_valid     = 1'b1;
        s_data      = 24'h100000;
        for (int i = 0; i < 1100; i++) begin
            if (env_a == 0 && env_b == 0) break;
            tick();
        end
        drain();
        envelope_in = 32'h7FFF_FFFF;
        s_valid     = 1'b1;
        for (int i = 0; i < 1300 && (n < 1025 || qb.size() != 0); i++) begin
            s_valid = (n < 1025);
            tick();
            if (smp_hs) begin
                checks++;
                if (smp_data_b < last_b) begin
                    errors++;
                    $display("FAIL ramp_monotonic: got %0d after %0d", smp_data_b, last_b);
                end
                last_b = smp_data_b;
            end
            if (smp_acc) begin
                n++;
                if (n == 1023) begin
                    checks++;
                    if (env_level_b === 32'h7FFF_FFFF) begin
                        errors++;
                        $display("FAIL ramp_early: got %h at accept 1023 expected below unity", env_level_b);
                    end
                end
                if (n == 1024) begin
                    checks++;
                    if (env_level_b !== 32'h7FFF_FFFF) begin
                        errors++;
                        $display("FAIL ramp_top: got %h at accept 1024 expected 7fffffff", env_level_b);
                    end
                end
            end
        end
        s_valid = 1'b0;
        checks++;
        if (n != 1025 || last_b !== 64'h100000) begin
            errors++;
            $display("FAIL ramp_final: got %0d accepts last %h expected 1025 last 100000", n, last_b);
        end
        drain();
    endtask

    task automatic test_backpressure();
        longint held = 0;
        envelope_in = 32'h3000_0000;
        s_valid     = 1'b1;
        s_data      = DW'($urandom);
        for (int t = 0; t < 20; t++) begin
            m_ready = !(t >= 6 && t < 11);
            tick();
            if (t == 6) held = smp_data_a;
            if (t >= 6 && t < 11) begin
                checks++;
                if (smp_s_ready !== 1'b0 || smp_m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready: got s_ready=%b m_valid=%b expected 0 1",
                             smp_s_ready, smp_m_valid);
                end
                checks++;
                if (smp_data_a !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %0d expected %0d", smp_data_a, held);
                end
            end
            if (smp_acc) s_data = DW'($urandom);
        end
        drain();
    endtask

    task automatic test_random();
        logic pending = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (!pending) begin
                s_valid = ($urandom % 3) != 0;
                s_data  = DW'($urandom);
            end
            if (($urandom % 8) == 0) begin
                case ($urandom % 4)
                    0: envelope_in = '0;
                    1: envelope_in = 32'h8000_0000 | $urandom;
                    default: envelope_in = $urandom;
                endcase
            end
            m_ready = ($urandom % 4) != 0;
            tick();
            pending = s_valid && !smp_acc;
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        envelope_in = 32'h0001_0000;
        m_ready     = 1'b1;
        s_valid     = 1'b1;
        s_data      = 24'd77;
        tick();
        s_data      = 24'd88;
        tick();
        s_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        env_a = 0;
        env_b = 0;
        checks++;
        if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL midreset_m_valid: got %b %b expected 0 0", m_valid_a, m_valid_b);
        end
        checks++;
        if (active_a !== 1'b0 || active_b !== 1'b0) begin
            errors++;
            $display("FAIL midreset_active: got %b %b expected 0 0", active_a, active_b);
        end
        checks++;
        if (env_level_a !== '0 || env_level_b !== '0) begin
            errors++;
            $display("FAIL midreset_env: got %h %h expected 0 0", env_level_a, env_level_b);
        end
        // Nothing from before reset may appear; tick flags any stray output.
        for (int i = 0; i < 4; i++) tick();
        envelope_in = 32'h0001_0000;
        send(24'd5);
        envelope_in = '0;
        send(24'd7);
        drain();
        tick();
        checks++;
        if (active_a !== 1'b0 || active_b !== 1'b0) begin
            errors++;
            $display("FAIL release_active: got %b %b expected 0 0", active_a, active_b);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_half();
        test_clamp();
        test_backpressure();
        test_random();
        test_ramp();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/envelope_vca.md
Name: envelope_vca

Overview:
- Voltage-controlled-amplifier stage that consumes the envelope generator's level output and applies it to a voice's audio sample stream.
- Sits between the oscillator/filter output and the voice mixer.
- Smooths the per-sample gain with a slew limiter so envelope steps do not cause zipper noise.
- Multiplies each sample by the gain in a 3-stage pipeline with valid/ready handshaking on both sides.

Parameters:
- DATA_WIDTH, 24, signed two's-complement sample width.
- ENVELOPE_WIDTH, 32, envelope width; unity gain = 2^(ENVELOPE_WIDTH-1)-1 (0x7FFFFFFF).
- SLEW_STEP, 32'h0020_0000, maximum gain change per accepted sample; 0 = no smoothing.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- envelope_in  in  ENVELOPE_WIDTH  target gain from envelope generator, unsigned
- s_data  in  DATA_WIDTH  input sample, signed
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept input
- m_data  out  DATA_WIDTH  scaled output sample, signed
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- env_level  out  ENVELOPE_WIDTH  current smoothed gain (env_cur)
- active  out  1  voice still producing non-silent output or data in flight

Behaviour:
- Reset: all stage-valid bits, m_valid, m_data, env_cur and env_level cleared to 0. active=0. s_ready=1 in the first cycle after reset. Reset mid-operation discards all in-flight samples.
- Target clamp: tgt = envelope_in with bit[EW-1] set ? 0x7FFFFFFF : envelope_in. Gain never exceeds unity.
- Advance: adv = ~m_valid | m_ready. s_ready = adv, combinational, with no dependency on s_valid. Accept = s_valid & s_ready.
- When adv=0, all stages hold and env_cur holds.
- Gain update happens on accept only.
  - If SLEW_STEP==0, or |tgt - env_cur| <= SLEW_STEP: env_cur <= tgt.
  - Else env_cur <= env_cur ± SLEW_STEP, moving toward tgt.
  - Comparisons are done at ENVELOPE_WIDTH+1 bits; no wrap-around.
- Gain used for a sample is the post-update env_cur value, i.e. the same value latched by the accepting edge.
- Stage 1 (accept edge): register sample s1_d and gain s1_g; v1 <= 1 on accept, else v1 <= 0 if adv.
- Stage 2: product p = s1_d * s1_g, signed × unsigned, DATA_WIDTH+ENVELOPE_WIDTH+1 bits; v2 <= v1 when adv.
- Stage 3: m_data <= (p + 2^(EW-2)) >>> (EW-1), an arithmetic shift with round-half-up; m_valid <= v2 when adv.
  - No saturation is needed because gain ≤ unity.
  - Unity gain returns the input sample exactly for all inputs.
- Latency: 3 cycles from accept edge to m_valid high with m_ready held 1.
- Throughput: one sample/cycle.
- Output hold: m_data/m_valid remain stable while m_valid & ~m_ready.
- Simultaneous events:
  - The output handshake and a new accept in the same cycle is a normal pipeline advance.
  - envelope_in changes while stalled: the new value is used at the next accept.
- active = (env_cur != 0) | v1 | v2 | m_valid.
- env_level = env_cur, registered.

Test Plan:
- Reset, then envelope_in=0x7FFFFFFF, SLEW_STEP=0, m_ready=1, samples 0x7FFFFF, 0x800000, 0x000001, -1 back-to-back -> m_data identical to the inputs, first m_valid 3 cycles after first accept, one output/cycle.
- SLEW_STEP=0, envelope_in=0x40000000, samples 1000, -1000, 3 -> outputs 500, -500, 2.
- Default SLEW_STEP, envelope_in jumps 0 -> 0x7FFFFFFF, stream of 1025 samples of 0x100000 -> env_level ramps in steps of 0x200000, reaching 0x7FFFFFFF on the 1024th accept. Output rises monotonically; final output 0x100000.
- envelope_in=0xFFFFFFFF, SLEW_STEP=0 -> env_level=0x7FFFFFFF; sample 12345 out as 12345.
- Backpressure: m_ready low for 5 cycles mid-stream with s_valid high -> s_ready low, m_data stable, no sample lost or duplicated; order preserved after release.
- Release to zero, then assert rst with 2 samples in flight -> the cycle after reset has m_valid=0, active=0, env_level=0. Apply envelope_in=0 with the pipeline drained -> active deasserts once the last sample leaves.
